mem_ctl: RTL
============

MEM_CTL -- requirements
Module: mem_ctl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 SHALL have parameter WAIT_CYC, default 2, meaning wait states inserted between request capture and array access (0..15).
REQ-003 SHALL have parameter DATA_W, default 32, meaning data port width; fixed multiple of 8, minimum 32.
REQ-004 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port CLR  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port MOV  input  1  memory-operation-valid request, four-phase handshake.
REQ-007 SHALL have port RW  input  1  1 = read, 0 = write.
REQ-008 SHALL have port TYPE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port ADDR  input  ADDR_W  byte address.
REQ-010 SHALL have port DIN  input  DATA_W  write data, right-justified.
REQ-011 SHALL have port DOUT  output  DATA_W  read data, zero-extended, right-justified.
REQ-012 SHALL have port MOC  output  1  memory-operation-complete.
REQ-013 SHALL have port ERR  output  1  access rejected; valid while MOC=1.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS, DONE.
REQ-016 SHALL, in IDLE on a rising edge with MOV=1, capture RW, TYPE, ADDR and DIN into internal registers, then go to WAIT (WAIT_CYC>0) or ACCESS (WAIT_CYC=0).
REQ-017 SHALL stay in WAIT for exactly WAIT_CYC cycles using a down-counter, then go to ACCESS; input changes during WAIT SHALL be ignored.
REQ-018 SHALL, in ACCESS, perform one read or write on the captured request and go to DONE the next edge; request-to-MOC latency = WAIT_CYC+2 cycles.
REQ-019 SHALL store data big-endian: most significant byte at the lowest address (word at A = mem[A],mem[A+1],mem[A+2],mem[A+3]).
REQ-020 SHALL, on write, update only the bytes selected by TYPE (1, 2 or 4) from DIN's low bytes; other bytes SHALL be unchanged.
REQ-021 SHALL, on read, load DOUT with the selected bytes zero-extended in the ACCESS cycle; DOUT SHALL hold its value until the next read's ACCESS.
REQ-022 SHALL assert MOC=1 throughout DONE and remain there until MOV=0 is sampled, then return to IDLE with MOC=0 on that edge.
REQ-023 SHALL treat TYPE=11 as an error: no array access, ERR=1 with MOC in DONE, DOUT unchanged.
REQ-024 SHALL clear ERR on leaving DONE.
REQ-025 SHALL not accept a new request until IDLE is re-entered; MOV held high across DONE->IDLE SHALL NOT start a second access (MOV must be sampled low first).

Reset
REQ-026 SHALL, on CLR=0, immediately force state IDLE, MOC=0, ERR=0, BUSY=0, DOUT=0, wait counter=0.
REQ-027 SHALL, if reset occurs in WAIT or ACCESS, abort the pending access with no array write.
REQ-028 SHALL not initialise memory array contents on reset; contents survive reset.

Configuration
REQ-029 SHALL support macro MEM_CTL_ALIGN_CHK_EN.
REQ-030 SHALL, with MEM_CTL_ALIGN_CHK_EN defined, reject halfword at odd address and word at address not multiple of 4: no array access, ERR=1 in DONE.
REQ-031 SHALL, without MEM_CTL_ALIGN_CHK_EN, force misaligned address low bits to zero (halfword bit0, word bits1:0) and complete normally with ERR=0; no wrap past 2**ADDR_W-1 is possible in either mode.

Verification
REQ-032 SHALL cover: write word 0xDEADBEEF @0x10, then read word @0x10 -> DOUT=0xDEADBEEF, ERR=0; byte read @0x10 -> 0x000000DE; @0x13 -> 0x000000EF.
REQ-033 SHALL cover: WAIT_CYC=2, MOV rises at edge n -> MOC=1 first seen after edge n+4; MOV dropped at edge m -> MOC=0 after edge m.
REQ-034 SHALL cover: halfword write 0x1234 @0x20 over word 0xAABBCCDD -> word read @0x20 = 0x1234CCDD.
REQ-035 SHALL cover: word read @0x22 -> with macro ERR=1 and DOUT unchanged; without macro DOUT = word @0x20, ERR=0; TYPE=11 -> ERR=1 in both builds.
REQ-036 SHALL cover: CLR=0 asserted in WAIT of write 0x55 @0x30 -> MOC=0, BUSY=0 immediately; byte read @0x30 after reset returns prior value.
REQ-037 SHALL cover: MOV held high 10 cycles -> exactly one access completes and MOC stays high until MOV drops.

Source files
------------

// File: rtl/mem_ctl.sv
//-----------------------------------------------------------------------------
// mem_ctl -- byte-addressed, big-endian memory controller with wait states
//
// A single request is captured from a four-phase MOV/MOC handshake, held for
// WAIT_CYC wait states, then performs one byte, halfword or word access on an
// internal byte array. MOC stays high until the requester drops MOV.
//
// Parameters
//   ADDR_W   : byte-address width; the array holds 2**ADDR_W bytes
//   WAIT_CYC : wait states between request capture and array access (0..15)
//   DATA_W   : data port width (multiple of 8, at least 32)
//
// Ports
//   CLK  in   clock, all state changes on the rising edge
//   CLR  in   asynchronous active-low reset
//   MOV  in   memory-operation-valid request
//   RW   in   1 = read, 0 = write
//   TYPE in   access size: 00 byte, 01 halfword, 10 word, 11 reserved (error)
//   ADDR in   byte address
//   DIN  in   write data, right-justified
//   DOUT out  read data, zero-extended, right-justified; held between reads
//   MOC  out  memory-operation-complete
//   ERR  out  access rejected; meaningful while MOC=1
//   BUSY out  high whenever the controller is not idle
//
// Build option
//   MEM_CTL_ALIGN_CHK_EN : when defined, misaligned halfword/word requests are
//   rejected with ERR=1. When undefined, the low address bits are cleared and
//   the access completes normally.
//
// The byte array is never reset, so its contents survive CLR.
//-----------------------------------------------------------------------------
module mem_ctl #(
   parameter int ADDR_W   = 8,
   parameter int WAIT_CYC = 2,
   parameter int DATA_W   = 32
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MOV,
   input  logic              RW,
   input  logic [1:0]        TYPE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] DIN,
   output logic [DATA_W-1:0] DOUT,
   output logic              MOC,
   output logic              ERR,
   output logic              BUSY
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [1:0] T_BYTE = 2'b00;
   localparam logic [1:0] T_HALF = 2'b01;
   localparam logic [1:0] T_WORD = 2'b10;

   // WAIT is left when the counter reads zero, so it is loaded with one less
   // than the number of wait states to spend exactly WAIT_CYC cycles there.
   localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic              err_q;

   // Captured request; data-path registers, deliberately not reset.
   logic              rw_q;
   logic [1:0]        type_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       din_q;

   logic [7:0]        mem [DEPTH];

   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic              req_err;
   logic              do_access;
   logic              wr_en;
   logic [31:0]       rd_word;
   logic [DATA_W-1:0] rd_ext;

   // Clear the address bits below the access size. With alignment checking
   // enabled a misaligned request never reaches the array, so the masking is
   // harmless in that build.
   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        t);
      logic [ADDR_W-1:0] r;
      r = a;
      case (t)
         T_HALF:  r[0]   = 1'b0;
         T_WORD:  r[1:0] = 2'b00;
         default: r      = a;
      endcase
      return r;
   endfunction

`ifdef MEM_CTL_ALIGN_CHK_EN
   function automatic logic misaligned(input logic [ADDR_W-1:0] a,
                                       input logic [1:0]        t);
      return ((t == T_HALF) && a[0]) || ((t == T_WORD) && (a[1:0] != 2'b00));
   endfunction

   assign req_err = (type_q == 2'b11) || misaligned(addr_q, type_q);
`else
   assign req_err = (type_q == 2'b11);
`endif

   // Byte lane addresses, most significant byte at the lowest address. An
   // aligned access never crosses the top of the array.
   assign a0 = align_addr(addr_q, type_q);
   assign a1 = a0 + ADDR_W'(1);
   assign a2 = a0 + ADDR_W'(2);
   assign a3 = a0 + ADDR_W'(3);

   assign do_access = (state == S_ACCESS) && !req_err;
   assign wr_en     = do_access && !rw_q;

   always_comb begin
      rd_word = '0;
      case (type_q)
         T_BYTE:  rd_word = {24'd0, mem[a0]};
         T_HALF:  rd_word = {16'd0, mem[a0], mem[a1]};
         T_WORD:  rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
         default: rd_word = '0;
      endcase
   end

   always_comb begin
      rd_ext       = '0;
      rd_ext[31:0] = rd_word;
   end

   // ---- request capture (IDLE) ----
   always_ff @(posedge CLK) begin
      if ((state == S_IDLE) && MOV) begin
         rw_q   <= RW;
         type_q <= TYPE;
         addr_q <= ADDR;
         din_q  <= DIN[31:0];
      end
   end

   // ---- array write (ACCESS) ----
   // A reset during WAIT or ACCESS forces IDLE asynchronously, so wr_en is
   // already low at the next edge and the pending write is dropped.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         case (type_q)
            T_BYTE: mem[a0] <= din_q[7:0];
            T_HALF: begin
               mem[a0] <= din_q[15:8];
               mem[a1] <= din_q[7:0];
            end
            T_WORD: begin
               mem[a0] <= din_q[31:24];
               mem[a1] <= din_q[23:16];
               mem[a2] <= din_q[15:8];
               mem[a3] <= din_q[7:0];
            end
            default: ;
         endcase
      end
   end

   // ---- control FSM, error flag and read register ----
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
         DOUT     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (MOV) begin
                  state    <= (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
                  wait_cnt <= CNT_LOAD;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= S_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_ACCESS: begin
               state <= S_DONE;
               err_q <= req_err;
               // Rejected accesses and writes leave DOUT untouched.
               if (do_access && rw_q) begin
                  DOUT <= rd_ext;
               end
            end
            S_DONE: begin
               // A new request is only accepted after MOV has been seen low,
               // which this exit condition guarantees.
               if (!MOV) begin
                  state <= S_IDLE;
                  err_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign MOC  = (state == S_DONE);
   assign ERR  = err_q;
   assign BUSY = (state != S_IDLE);

endmodule
